// File: rtl/mdl_dmasched_if.sv
// mdl_dmasched_if: bundles the DMA sequencer's control inputs, 68000 bus
// handshake and the front-end outputs.
//   master : the sequencer (drives BR/BGACK, ring, DMA_ACT, address, status)
//   slave  : the surrounding logic (drives start/abort, clock enable, BG/AS/DTACK)
interface mdl_dmasched_if #(
    parameter int unsigned ADDR_W = 23,
    parameter int unsigned LEN_W  = 9
);
    logic              i_CLK4M_PCEN_n;
    logic              i_XFER_START;
    logic              i_XFER_WR;
    logic [LEN_W-1:0]  i_XFER_LEN;
    logic [ADDR_W-1:0] i_XFER_ADDR;
    logic              i_XFER_ABORT;
    logic              i_BG_n;
    logic              i_AS_n;
    logic              i_DTACK_n;
    logic              o_BR_n;
    logic              o_BGACK_n;
    logic [7:0]        o_ROT8;
    logic              o_DMA_ACT;
    logic              o_DMA_WR_ACT_n;
    logic [ADDR_W-1:0] o_ADDR;
    logic              o_WORD_DONE;
    logic              o_BUSY;
    logic              o_XFER_DONE;

    modport master (
        input  i_CLK4M_PCEN_n, i_XFER_START, i_XFER_WR, i_XFER_LEN, i_XFER_ADDR,
               i_XFER_ABORT, i_BG_n, i_AS_n, i_DTACK_n,
        output o_BR_n, o_BGACK_n, o_ROT8, o_DMA_ACT, o_DMA_WR_ACT_n, o_ADDR,
               o_WORD_DONE, o_BUSY, o_XFER_DONE
    );

    modport slave (
        output i_CLK4M_PCEN_n, i_XFER_START, i_XFER_WR, i_XFER_LEN, i_XFER_ADDR,
               i_XFER_ABORT, i_BG_n, i_AS_n, i_DTACK_n,
        input  o_BR_n, o_BGACK_n, o_ROT8, o_DMA_ACT, o_DMA_WR_ACT_n, o_ADDR,
               o_WORD_DONE, o_BUSY, o_XFER_DONE
    );
endinterface

// File: rtl/mdl_dmasched.sv
// mdl_dmasched: DMA sequencer. Acquires the 68000 bus via BR/BG/BGACK, runs
// the 8-phase one-hot ROT8 timing ring for each word, and keeps the word
// address and remaining-length counters.
//   i_MCLK  : master clock; state moves only on steps (i_CLK4M_PCEN_n low)
//   i_RST   : asynchronous active-high reset
//   bus     : control/handshake/front-end signals (mdl_dmasched_if.master)
module mdl_dmasched #(
    parameter int unsigned ADDR_W = 23,
    parameter int unsigned LEN_W  = 9
) (
    input  logic           i_MCLK,
    input  logic           i_RST,
    mdl_dmasched_if.master bus
);
    localparam logic [7:0] RING_RST = 8'h01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAITBUS,
        S_XFER,
        S_RELEASE
    } state_t;

    state_t            state_q, state_d;
    logic              br_n_q, br_n_d;
    logic              bgack_n_q, bgack_n_d;
    logic [7:0]        rot_q, rot_d;
    logic              act_q, act_d;
    logic              wr_act_n_q, wr_act_n_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic              abort_q, abort_d;
    logic              word_done_q, word_done_d;
    logic              busy_q, busy_d;
    logic              xfer_done_q, xfer_done_d;

    logic              step_c;
    logic [LEN_W-1:0]  cnt_dec_c;

    assign step_c    = ~bus.i_CLK4M_PCEN_n;
    // Length 0 loads as 0 and wraps through all ones, giving 2^LEN_W words.
    assign cnt_dec_c = cnt_q - LEN_W'(1);

    // State and output registers
    always_ff @(posedge i_MCLK or posedge i_RST) begin
        if (i_RST) begin
            state_q     <= S_IDLE;
            br_n_q      <= 1'b1;
            bgack_n_q   <= 1'b1;
            rot_q       <= RING_RST;
            act_q       <= 1'b0;
            wr_act_n_q  <= 1'b1;
            addr_q      <= '0;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            abort_q     <= 1'b0;
            word_done_q <= 1'b0;
            busy_q      <= 1'b0;
            xfer_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            br_n_q      <= br_n_d;
            bgack_n_q   <= bgack_n_d;
            rot_q       <= rot_d;
            act_q       <= act_d;
            wr_act_n_q  <= wr_act_n_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            abort_q     <= abort_d;
            word_done_q <= word_done_d;
            busy_q      <= busy_d;
            xfer_done_q <= xfer_done_d;
        end
    end

    // Next-state and output logic; pulses self-clear on the following MCLK
    always_comb begin
        state_d     = state_q;
        br_n_d      = br_n_q;
        bgack_n_d   = bgack_n_q;
        rot_d       = rot_q;
        act_d       = act_q;
        wr_act_n_d  = wr_act_n_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        abort_d     = abort_q;
        word_done_d = 1'b0;
        busy_d      = busy_q;
        xfer_done_d = 1'b0;

        if (step_c) begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.i_XFER_START) begin
                        wr_d    = bus.i_XFER_WR;
                        cnt_d   = bus.i_XFER_LEN;
                        addr_d  = bus.i_XFER_ADDR;
                        abort_d = 1'b0;
                        busy_d  = 1'b1;
                        br_n_d  = 1'b0;
                        state_d = S_REQ;
                    end
                end
                S_REQ: begin
                    if (bus.i_XFER_ABORT) begin
                        br_n_d      = 1'b1;
                        busy_d      = 1'b0;
                        xfer_done_d = 1'b1;
                        state_d     = S_IDLE;
                    end else if (!bus.i_BG_n) begin
                        state_d = S_WAITBUS;
                    end
                end
                S_WAITBUS: begin
                    if (bus.i_XFER_ABORT) begin
                        br_n_d      = 1'b1;
                        busy_d      = 1'b0;
                        xfer_done_d = 1'b1;
                        state_d     = S_IDLE;
                    end else if (bus.i_AS_n && bus.i_DTACK_n) begin
                        // Previous master has finished its cycle: take the bus
                        bgack_n_d  = 1'b0;
                        br_n_d     = 1'b1;
                        act_d      = 1'b1;
                        wr_act_n_d = ~wr_q;
                        state_d    = S_XFER;
                    end
                end
                S_XFER: begin
                    if (bus.i_XFER_ABORT) begin
                        abort_d = 1'b1;
                    end
                    // Bit 5 is the DTACK wait phase
                    if (!(rot_q[5] && bus.i_DTACK_n)) begin
                        rot_d = {rot_q[6:0], rot_q[7]};
                    end
                    if (rot_q[7]) begin
                        word_done_d = 1'b1;
                        addr_d      = addr_q + ADDR_W'(1);
                        cnt_d       = cnt_dec_c;
                        if ((cnt_dec_c == '0) || abort_q || bus.i_XFER_ABORT) begin
                            act_d      = 1'b0;
                            wr_act_n_d = 1'b1;
                            rot_d      = RING_RST;
                            state_d    = S_RELEASE;
                        end
                    end
                end
                S_RELEASE: begin
                    bgack_n_d   = 1'b1;
                    xfer_done_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign bus.o_BR_n         = br_n_q;
    assign bus.o_BGACK_n      = bgack_n_q;
    assign bus.o_ROT8         = rot_q;
    assign bus.o_DMA_ACT      = act_q;
    assign bus.o_DMA_WR_ACT_n = wr_act_n_q;
    assign bus.o_ADDR         = addr_q;
    assign bus.o_WORD_DONE    = word_done_q;
    assign bus.o_BUSY         = busy_q;
    assign bus.o_XFER_DONE    = xfer_done_q;
endmodule

// File: tb/tb_mdl_dmasched.sv
// tb_mdl_dmasched: directed bench for mdl_dmasched with a procedural
// transfer model compared against the DUT on every MCLK falling edge.
module tb_mdl_dmasched;
    localparam int unsigned ADDR_W     = 23;
    localparam int unsigned LEN_W      = 9;
    localparam int unsigned NWORDS_MAX = 1 << LEN_W;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mdl_dmasched_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();
    mdl_dmasched #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .i_MCLK (clk),
        .i_RST  (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endfunction

    // ---------------- model: expected outputs ----------------
    logic              e_br_n, e_bgack_n, e_act, e_wr_n, e_wd, e_busy, e_xd;
    logic [7:0]        e_rot;
    logic [ADDR_W-1:0] e_addr;
    logic              s_start, s_wr, s_abort, s_bg_n, s_as_n, s_dtack_n;
    logic [LEN_W-1:0]  s_len;
    logic [ADDR_W-1:0] s_addr;

    task automatic model_reset();
        e_br_n = 1'b1; e_bgack_n = 1'b1; e_rot = 8'h01; e_act = 1'b0;
        e_wr_n = 1'b1; e_addr = '0; e_wd = 1'b0; e_busy = 1'b0; e_xd = 1'b0;
    endtask

    // Waits for the next step; clears pulses on every MCLK edge in between.
    task automatic step_wait(output bit got_rst);
        got_rst = 1'b0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                got_rst = 1'b1;
                return;
            end
            e_wd = 1'b0;
            e_xd = 1'b0;
            if (bus.i_CLK4M_PCEN_n == 1'b0) begin
                s_start = bus.i_XFER_START; s_wr = bus.i_XFER_WR;
                s_len = bus.i_XFER_LEN; s_addr = bus.i_XFER_ADDR;
                s_abort = bus.i_XFER_ABORT; s_bg_n = bus.i_BG_n;
                s_as_n = bus.i_AS_n; s_dtack_n = bus.i_DTACK_n;
                return;
            end
        end
    endtask

    // One transfer after another, written as the protocol reads: request,
    // wait for grant, wait for bus free, N words of 8 phases, release.
    task automatic run_model();
        bit r, ab, fin, wr;
        int unsigned total, words;
        logic [ADDR_W-1:0] a0;
        forever begin
            step_wait(r); if (r) return;
            if (!s_start) continue;
            wr = s_wr; a0 = s_addr; words = 0; ab = 1'b0;
            total = (s_len == '0) ? NWORDS_MAX : 32'(s_len);
            e_addr = a0; e_busy = 1'b1; e_br_n = 1'b0;
            forever begin
                step_wait(r); if (r) return;
                if (s_abort) begin ab = 1'b1; break; end
                if (!s_bg_n) break;
            end
            if (!ab) forever begin
                step_wait(r); if (r) return;
                if (s_abort) begin ab = 1'b1; break; end
                if (s_as_n && s_dtack_n) break;
            end
            if (ab) begin
                e_br_n = 1'b1; e_busy = 1'b0; e_xd = 1'b1;
                continue;
            end
            e_br_n = 1'b1; e_bgack_n = 1'b0; e_act = 1'b1; e_wr_n = ~wr;
            fin = 1'b0;
            while (!fin) begin
                // b = ring bit being entered; 8 means leaving bit 7
                for (int b = 1; b <= 8; b++) begin
                    do begin
                        step_wait(r); if (r) return;
                        if (s_abort) ab = 1'b1;
                    end while (b == 6 && s_dtack_n);
                    if (b < 8) begin
                        e_rot = 8'(1 << b);
                    end else begin
                        words++;
                        e_wd = 1'b1;
                        e_rot = 8'h01;
                        e_addr = ADDR_W'(32'(a0) + words);
                        if (words == total || ab) fin = 1'b1;
                    end
                end
            end
            e_act = 1'b0; e_wr_n = 1'b1;
            step_wait(r); if (r) return;
            e_bgack_n = 1'b1; e_xd = 1'b1; e_busy = 1'b0;
        end
    endtask

    initial begin
        forever begin
            model_reset();
            wait (rst == 1'b0);
            run_model();
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        check("br_n",      32'(bus.o_BR_n),         32'(e_br_n));
        check("bgack_n",   32'(bus.o_BGACK_n),      32'(e_bgack_n));
        check("rot8",      32'(bus.o_ROT8),         32'(e_rot));
        check("dma_act",   32'(bus.o_DMA_ACT),      32'(e_act));
        check("wr_act_n",  32'(bus.o_DMA_WR_ACT_n), 32'(e_wr_n));
        check("addr",      32'(bus.o_ADDR),         32'(e_addr));
        check("word_done", 32'(bus.o_WORD_DONE),    32'(e_wd));
        check("busy",      32'(bus.o_BUSY),         32'(e_busy));
        check("xfer_done", 32'(bus.o_XFER_DONE),    32'(e_xd));
    end

    // ---------------- event counters ----------------
    int n_act = 0, n_wd = 0, n_xd = 0, n_wract = 0;
    always @(posedge clk) if (!rst && !bus.i_CLK4M_PCEN_n && bus.o_DMA_ACT) n_act++;
    always @(negedge clk) begin
        if (bus.o_WORD_DONE) n_wd++;
        if (bus.o_XFER_DONE) n_xd++;
        if (bus.o_DMA_ACT && !bus.o_DMA_WR_ACT_n) n_wract++;
    end

    // ---------------- stimulus ----------------
    // One idle MCLK then one step; returns at the falling edge after the step.
    task automatic step();
        @(negedge clk);
        bus.i_CLK4M_PCEN_n = 1'b0;
        @(negedge clk);
        bus.i_CLK4M_PCEN_n = 1'b1;
    endtask

    task automatic begin_xfer(input bit wr, input int len, input int addr, input bit grant);
        bus.i_XFER_WR = wr;
        bus.i_XFER_LEN = LEN_W'(len);
        bus.i_XFER_ADDR = ADDR_W'(addr);
        bus.i_XFER_START = 1'b1;
        step();
        bus.i_XFER_START = 1'b0;
        bus.i_BG_n = ~grant;
    endtask

    // Steps until idle, answering DTACK at bit 5 (optionally late on one word)
    // and optionally pulsing abort at bit 3 of a chosen word.
    task automatic run_xfer(input int wait_word, input int wait_n, input int abort_word, input int max_steps);
        int left = wait_n;
        int words = 0;
        int k = 0;
        while (bus.o_BUSY && k < max_steps) begin
            bus.i_DTACK_n = 1'b1;
            bus.i_XFER_ABORT = 1'b0;
            if (bus.o_DMA_ACT && bus.o_ROT8 == 8'h20) begin
                if (words == wait_word && left > 0) left--;
                else bus.i_DTACK_n = 1'b0;
            end
            if (words == abort_word && bus.o_DMA_ACT && bus.o_ROT8 == 8'h08) bus.i_XFER_ABORT = 1'b1;
            step();
            if (bus.o_WORD_DONE) words++;
            k++;
        end
        bus.i_XFER_ABORT = 1'b0;
        bus.i_DTACK_n = 1'b1;
        bus.i_BG_n = 1'b1;
        check("xfer_finishes_in_budget", 32'(bus.o_BUSY), 32'd0);
        @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_br_n"},      32'(bus.o_BR_n),         32'd1);
        check({tag, "_bgack_n"},   32'(bus.o_BGACK_n),      32'd1);
        check({tag, "_rot8"},      32'(bus.o_ROT8),         32'h01);
        check({tag, "_dma_act"},   32'(bus.o_DMA_ACT),      32'd0);
        check({tag, "_wr_act_n"},  32'(bus.o_DMA_WR_ACT_n), 32'd1);
        check({tag, "_addr"},      32'(bus.o_ADDR),         32'd0);
        check({tag, "_word_done"}, 32'(bus.o_WORD_DONE),    32'd0);
        check({tag, "_busy"},      32'(bus.o_BUSY),         32'd0);
        check({tag, "_xfer_done"}, 32'(bus.o_XFER_DONE),    32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, w0, x0, r0, k;
        bus.i_CLK4M_PCEN_n = 1'b1; bus.i_XFER_START = 1'b0; bus.i_XFER_WR = 1'b0;
        bus.i_XFER_LEN = '0; bus.i_XFER_ADDR = '0; bus.i_XFER_ABORT = 1'b0;
        bus.i_BG_n = 1'b1; bus.i_AS_n = 1'b1; bus.i_DTACK_n = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;
        repeat (2) step();

        // Read, LEN=3 @0x100, grant 2 steps after BR, BG dropped in XFER
        a0 = n_act; w0 = n_wd; x0 = n_xd; r0 = n_wract;
        begin_xfer(1'b0, 3, 32'h100, 1'b0);
        check("rd_br_fall", 32'(bus.o_BR_n), 32'd0);
        check("rd_busy", 32'(bus.o_BUSY), 32'd1);
        step();
        bus.i_BG_n = 1'b0;
        step();
        check("rd_bgack_wait", 32'(bus.o_BGACK_n), 32'd1);
        step();
        check("rd_bgack_fall", 32'(bus.o_BGACK_n), 32'd0);
        check("rd_br_rise", 32'(bus.o_BR_n), 32'd1);
        bus.i_BG_n = 1'b1;
        bus.i_XFER_START = 1'b1;
        step();
        bus.i_XFER_START = 1'b0;
        run_xfer(-1, 0, -1, 200);
        check("rd_ring_steps", 32'(n_act - a0), 32'd24);
        check("rd_words", 32'(n_wd - w0), 32'd3);
        check("rd_done_pulses", 32'(n_xd - x0), 32'd1);
        check("rd_addr_end", 32'(bus.o_ADDR), 32'h000103);
        check("rd_no_write", 32'(n_wract - r0), 32'd0);
        check("rd_bgack_end", 32'(bus.o_BGACK_n), 32'd1);

        // Write, LEN=2, three DTACK wait states on word 1
        a0 = n_act; w0 = n_wd; r0 = n_wract;
        begin_xfer(1'b1, 2, 32'h2000, 1'b1);
        run_xfer(0, 3, -1, 200);
        check("wr_ring_steps", 32'(n_act - a0), 32'd19);
        check("wr_words", 32'(n_wd - w0), 32'd2);
        check("wr_act_cycles", 32'(n_wract - r0), 32'd38);
        check("wr_addr_end", 32'(bus.o_ADDR), 32'h002002);

        // Bus contention: AS held low for 5 steps after grant
        w0 = n_wd;
        bus.i_AS_n = 1'b0;
        begin_xfer(1'b0, 1, 32'h40, 1'b1);
        step();
        repeat (5) step();
        check("ct_bgack_held", 32'(bus.o_BGACK_n), 32'd1);
        bus.i_AS_n = 1'b1;
        step();
        check("ct_bgack_fall", 32'(bus.o_BGACK_n), 32'd0);
        run_xfer(-1, 0, -1, 200);
        check("ct_words", 32'(n_wd - w0), 32'd1);

        // Abort at bit 3 of word 4 of a 10-word read
        w0 = n_wd; x0 = n_xd;
        begin_xfer(1'b0, 10, 32'h400, 1'b1);
        run_xfer(-1, 0, 3, 400);
        check("ab_words", 32'(n_wd - w0), 32'd4);
        check("ab_addr_end", 32'(bus.o_ADDR), 32'h000404);
        check("ab_done_pulses", 32'(n_xd - x0), 32'd1);
        check("ab_bgack_end", 32'(bus.o_BGACK_n), 32'd1);

        // Abort while still requesting the bus
        begin_xfer(1'b0, 5, 32'h10, 1'b0);
        bus.i_XFER_ABORT = 1'b1;
        step();
        bus.i_XFER_ABORT = 1'b0;
        check("rq_abort_br", 32'(bus.o_BR_n), 32'd1);
        check("rq_abort_done", 32'(bus.o_XFER_DONE), 32'd1);
        check("rq_abort_busy", 32'(bus.o_BUSY), 32'd0);
        step();

        // Start and abort on the same idle step: start wins
        w0 = n_wd;
        bus.i_XFER_ABORT = 1'b1;
        begin_xfer(1'b0, 1, 32'h80, 1'b1);
        bus.i_XFER_ABORT = 1'b0;
        check("sa_busy", 32'(bus.o_BUSY), 32'd1);
        run_xfer(-1, 0, -1, 200);
        check("sa_words", 32'(n_wd - w0), 32'd1);

        // Length 0 = 512 words, address wraps
        w0 = n_wd;
        begin_xfer(1'b0, 0, 32'h7FFFFE, 1'b1);
        run_xfer(-1, 0, -1, 5000);
        check("lz_words", 32'(n_wd - w0), 32'd512);
        check("lz_addr_end", 32'(bus.o_ADDR), 32'h0001FE);

        // Async reset at ring bit 4 of a write, then a fresh transfer
        begin_xfer(1'b1, 2, 32'h3000, 1'b1);
        k = 0;
        while (!(bus.o_DMA_ACT && bus.o_ROT8 == 8'h10) && k < 50) begin
            step();
            k++;
        end
        check("rs_reached_bit4", 32'(bus.o_ROT8), 32'h10);
        #2 rst = 1'b1;
        #1 check_reset_vals("async_rst");
        @(negedge clk);
        rst = 1'b0;
        bus.i_BG_n = 1'b1;
        step();
        w0 = n_wd;
        begin_xfer(1'b0, 1, 32'h55, 1'b1);
        run_xfer(-1, 0, -1, 200);
        check("rs_words", 32'(n_wd - w0), 32'd1);
        check("rs_addr_end", 32'(bus.o_ADDR), 32'h000056);

        repeat (2) step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mdl_dmasched.md
Name: mdl_dmasched

Overview:
- DMA sequencer that drives the bus-control front end (UDS/LDS/AS/R/W generator).
- Acquires the 68000 bus via BR/BG/BGACK and produces the 8-phase one-hot ROT8 timing ring, DMA_ACT and DMA_WR_ACT_n.
- Also provides the word address counter and the block-transfer word counter.
- Sits between the bubble-buffer transfer logic and the bus front end; one instance per chip.

Parameters:
ADDR_W, 23, word address width (68000 A23..A1)
LEN_W, 9, transfer length counter width; length value 0 means 2^LEN_W words

Ports:
i_MCLK  in  1  master clock
i_RST  in  1  asynchronous reset, active-high
i_CLK4M_PCEN_n  in  1  4 MHz clock enable, active-low; all state advances only on i_MCLK rising edge with this low ("step")
i_XFER_START  in  1  start request, sampled in IDLE only
i_XFER_WR  in  1  direction: 1 = write to 68000 bus, 0 = read from bus; latched at start
i_XFER_LEN  in  LEN_W  word count, latched at start
i_XFER_ADDR  in  ADDR_W  start word address, latched at start
i_XFER_ABORT  in  1  request early termination
i_BG_n  in  1  68000 bus grant
i_AS_n  in  1  bus address strobe (observed to detect bus free)
i_DTACK_n  in  1  data acknowledge
o_BR_n  out  1  bus request
o_BGACK_n  out  1  bus grant acknowledge
o_ROT8  out  8  one-hot timing ring to the front end
o_DMA_ACT  out  1  DMA bus cycle active
o_DMA_WR_ACT_n  out  1  0 = write cycle in progress
o_ADDR  out  ADDR_W  current word address
o_WORD_DONE  out  1  one-MCLK pulse on the step completing each word
o_BUSY  out  1  high from accepted start until return to IDLE
o_XFER_DONE  out  1  one-MCLK pulse on entry to IDLE after a transfer or abort

Behaviour:
- Reset (async, any time, including mid-cycle):
  - o_BR_n = 1, o_BGACK_n = 1, o_ROT8 = 8'h01, o_DMA_ACT = 0, o_DMA_WR_ACT_n = 1
  - o_ADDR = 0, counters = 0, o_WORD_DONE = 0, o_BUSY = 0, o_XFER_DONE = 0
  - State = IDLE.
- All transitions below occur on steps only; i_START/ABORT/BG/AS/DTACK are sampled on steps.
- FSM states:
  - IDLE: on i_XFER_START, latch direction, length and address; set o_BUSY = 1; o_BR_n = 0 -> REQ.
  - REQ: wait for i_BG_n = 0 -> WAITBUS. Abort here: o_BR_n = 1, pulse done -> IDLE.
  - WAITBUS: wait for i_AS_n = 1 and i_DTACK_n = 1 on the same step; then o_BGACK_n = 0, o_BR_n = 1 -> XFER. Abort here behaves as in REQ.
  - XFER:
    - o_DMA_ACT = 1; o_DMA_WR_ACT_n = ~latched_wr.
    - Ring rotates left one bit per step (01 -> 02 -> ... -> 80 -> 01).
    - DTACK wait: the ring holds at bit 5 while i_DTACK_n = 1 at the step; it advances to bit 6 on the first step with i_DTACK_n = 0. No timeout.
    - On the step leaving bit 7: o_WORD_DONE pulses, o_ADDR increments (wraps modulo 2^ADDR_W), and the remaining count decrements.
    - If the count reaches 0, or an abort is pending -> RELEASE. Otherwise the next word starts immediately at bit 0.
  - RELEASE: on entry o_DMA_ACT = 0, o_DMA_WR_ACT_n = 1, ring = 01. On the next step o_BGACK_n = 1, o_XFER_DONE pulses, o_BUSY = 0 -> IDLE.
- Words per transfer = i_XFER_LEN, or 2^LEN_W if it is 0. Minimum word time is 8 steps (2 us at 4 MHz).
- Abort:
  - Abort in XFER is latched (sticky) and never truncates a word; the current word completes to the bit-7 exit.
  - Abort coincident with the final word's bit-7 exit produces the same result as normal completion.
- i_XFER_START while o_BUSY = 1 is ignored.
- Start and abort asserted on the same IDLE step: the start is accepted and the abort is ignored.
- i_BG_n negating during XFER is ignored; bus ownership is held by BGACK.
- The ring is never all-zero and never multi-hot.

Test Plan:
- Read transfer: LEN = 3, ADDR = 0x000100, WR = 0, BG granted 2 steps after BR, AS/DTACK idle, DTACK low at each bit 5 -> BR falls 1 step after start; BGACK falls and BR rises on WAITBUS exit; 24 ring steps; o_WORD_DONE pulses 3 times; o_ADDR = 0x000103; DMA_ACT falls; BGACK rises 1 step later with a single o_XFER_DONE pulse; DMA_WR_ACT_n = 1 throughout.
- Write transfer with wait states: LEN = 2, WR = 1, DTACK held high for 3 steps at bit 5 of word 1 -> ring holds at 8'h20 for 3 extra steps; DMA_WR_ACT_n = 0 during XFER; total 19 ring steps.
- Bus contention: BG given while i_AS_n = 0 for 5 steps -> BGACK stays 1 until the first step with AS_n = 1 and DTACK_n = 1.
- Abort mid-word: LEN = 10, abort pulsed at bit 3 of word 4 -> word 4 completes; exactly 4 o_WORD_DONE pulses; ADDR = start + 4; done pulse; bus released.
- Length zero and wrap: LEN = 0, ADDR = 0x7FFFFE -> 512 words; o_ADDR wraps through 0x000000 and ends at 0x0001FE.
- Async reset asserted at ring bit 4 of a write -> all outputs return to their reset values immediately without waiting for an MCLK edge; a new start after release runs normally.
